// File: rtl/rca_pkg.sv
// Shared types and helpers for the parametrizable ripple-carry adder.
// The optional RCA_OVERFLOW_EN build is handled in the top level only.
package rca_pkg;

  localparam int RCA_DEFAULT_N = 4;

  typedef struct packed {
    logic s;
    logic co;
  } fa_out_t;

  // One full-adder cell: sum and carry-out from two operand bits and carry-in.
  function automatic fa_out_t fa_eval(input logic a, input logic b, input logic ci);
    fa_out_t r;
    r.s  = a ^ b ^ ci;
    r.co = (a & b) | (ci & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/rca_full_adder.sv
// Purely combinational 1-bit full adder, the repeated cell of the carry chain.
module rca_full_adder
  import rca_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_out_t res_s;

  assign res_s = fa_eval(a, b, ci);
  assign s     = res_s.s;
  assign co    = res_s.co;

endmodule

// File: rtl/rca_parametrizable.sv
// N-bit ripple-carry adder with a registered result (one cycle latency).
// Define RCA_OVERFLOW_EN to add the registered two's-complement overflow output Ovf.
module rca_parametrizable
  import rca_pkg::*;
#(
  parameter int N = RCA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         valid_in,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         valid_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic         Ovf
`endif
);

  logic [N:0]   carry_s;
  logic [N-1:0] sum_s;

  assign carry_s[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_chain
      rca_full_adder u_fa (
        .a  (A[i]),
        .b  (B[i]),
        .ci (carry_s[i]),
        .s  (sum_s[i]),
        .co (carry_s[i+1])
      );
    end
  endgenerate

`ifdef RCA_OVERFLOW_EN
  // Result register: captures the chain only on valid samples, so idle X inputs never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= {N{1'b0}};
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        Sum  <= sum_s;
        Cout <= carry_s[N];
        Ovf  <= carry_s[N] ^ carry_s[N-1];
      end
    end
  end
`else
  // Result register: captures the chain only on valid samples, so idle X inputs never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= {N{1'b0}};
      Cout      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        Sum  <= sum_s;
        Cout <= carry_s[N];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rca_parametrizable.sv
// Directed and sweep checks for rca_parametrizable at N=4, plus random vectors at N=1 and N=16.
`timescale 1ns/1ps
module tb_rca_parametrizable;

  logic clk;
  logic rst_n;

  logic [3:0]  a4, b4;
  logic        cin4, vin4;
  logic [3:0]  sum4;
  logic        cout4, vout4;

  logic [0:0]  a1, b1;
  logic        cin1, vin1;
  logic [0:0]  sum1;
  logic        cout1, vout1;

  logic [15:0] a16, b16;
  logic        cin16, vin16;
  logic [15:0] sum16;
  logic        cout16, vout16;

`ifdef RCA_OVERFLOW_EN
  logic ovf4, ovf1, ovf16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rca_parametrizable #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .valid_in(vin4),
    .Sum(sum4), .Cout(cout4), .valid_out(vout4)
`ifdef RCA_OVERFLOW_EN
    , .Ovf(ovf4)
`endif
  );

  rca_parametrizable #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .valid_in(vin1),
    .Sum(sum1), .Cout(cout1), .valid_out(vout1)
`ifdef RCA_OVERFLOW_EN
    , .Ovf(ovf1)
`endif
  );

  rca_parametrizable #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .valid_in(vin16),
    .Sum(sum16), .Cout(cout16), .valid_out(vout16)
`ifdef RCA_OVERFLOW_EN
    , .Ovf(ovf16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the N=4 outputs against the expected values.
  task automatic check4(input string tag, input logic [3:0] es, input logic ec,
                        input logic ev, input logic eo);
    check({tag, ".sum"},   {60'd0, sum4},  {60'd0, es});
    check({tag, ".cout"},  {63'd0, cout4}, {63'd0, ec});
    check({tag, ".valid"}, {63'd0, vout4}, {63'd0, ev});
`ifdef RCA_OVERFLOW_EN
    check({tag, ".ovf"},   {63'd0, ovf4},  {63'd0, eo});
`endif
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    a4 = a; b4 = b; cin4 = c; vin4 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed overflow model: operands of equal sign giving a result of the other sign.
  function automatic logic ovf_model(input logic am, input logic bm, input logic rm);
    return (am == bm) && (rm != am);
  endfunction

  initial begin
    logic [4:0]  r5;
    logic [1:0]  r2;
    logic [16:0] r17;
    logic [3:0]  held_s;
    logic        held_c;

    rst_n = 1'b0;
    drive4(4'd0, 4'd0, 1'b0, 1'b0);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; vin1 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; vin16 = 1'b0;

    #2;
    check4("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    check("reset.n1", {62'd0, cout1, sum1}, 64'd0);
    check("reset.n16", {47'd0, cout16, sum16}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Directed vectors
    drive4(4'd1, 4'd2, 1'b0, 1'b1);   tick(); check4("t1",  4'd3,  1'b0, 1'b1, 1'b0);
    drive4(4'd6, 4'd3, 1'b0, 1'b1);   tick(); check4("t2",  4'd9,  1'b0, 1'b1, 1'b1);
    drive4(4'd15, 4'd1, 1'b0, 1'b1);  tick(); check4("t3a", 4'd0,  1'b1, 1'b1, 1'b0);
    drive4(4'd10, 4'd5, 1'b1, 1'b1);  tick(); check4("t3b", 4'd0,  1'b1, 1'b1, 1'b0);
    drive4(4'd15, 4'd15, 1'b1, 1'b1); tick(); check4("t4",  4'd15, 1'b1, 1'b1, 1'b0);
    drive4(4'd15, 4'd0, 1'b1, 1'b1);  tick(); check4("t4b", 4'd0,  1'b1, 1'b1, 1'b0);

    // Reset between edges with a valid sample pending
    drive4(4'd6, 4'd3, 1'b0, 1'b1);   tick(); check4("t5.load", 4'd9, 1'b0, 1'b1, 1'b1);
    drive4(4'd2, 4'd2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check4("t5.async", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); check4("t5.held", 4'd0, 1'b0, 1'b0, 1'b0);
    drive4(4'd0, 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick(); check4("t5.idle", 4'd0, 1'b0, 1'b0, 1'b0);
    drive4(4'd1, 4'd1, 1'b0, 1'b1);   tick(); check4("t5.first", 4'd2, 1'b0, 1'b1, 1'b0);

    // Back-to-back, then idle with X operands
    drive4(4'd7, 4'd1, 1'b0, 1'b1);   tick(); check4("t6a", 4'd8,  1'b0, 1'b1, 1'b1);
    drive4(4'd9, 4'd9, 1'b0, 1'b1);   tick(); check4("t6b", 4'd2,  1'b1, 1'b1, 1'b1);
    drive4(4'd4, 4'd3, 1'b1, 1'b1);   tick(); check4("t6c", 4'd8,  1'b0, 1'b1, 1'b1);
    drive4(4'bxxxx, 4'bxxxx, 1'bx, 1'b0); tick(); check4("t6.idle", 4'd8, 1'b0, 1'b0, 1'b1);
    tick(); check4("t6.idle2", 4'd8, 1'b0, 1'b0, 1'b1);

    // Exhaustive N=4 sweep, one operand set per cycle
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive4(a[3:0], b[3:0], c[0], 1'b1);
          r5 = 5'(a) + 5'(b) + 5'(c);
          tick();
          check4($sformatf("sweep %0d+%0d+%0d", a, b, c), r5[3:0], r5[4], 1'b1,
                 ovf_model(a[3], b[3], r5[3]));
        end
      end
    end
    drive4(4'd0, 4'd0, 1'b0, 1'b0);

    // Random vectors for N=1 and N=16
    for (int k = 0; k < 200; k++) begin
      a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
      vin1 = 1'b1; vin16 = 1'b1;
      r2  = 2'(a1) + 2'(b1) + 2'(cin1);
      r17 = 17'(a16) + 17'(b16) + 17'(cin16);
      tick();
      check($sformatf("n1 #%0d", k),  {62'd0, cout1, sum1},   {62'd0, r2});
      check($sformatf("n16 #%0d", k), {47'd0, cout16, sum16}, {47'd0, r17});
      check($sformatf("nv #%0d", k),  {62'd0, vout1, vout16}, 64'd3);
`ifdef RCA_OVERFLOW_EN
      check($sformatf("n1.ovf #%0d", k),  {63'd0, ovf1},  {63'd0, ovf_model(a1[0], b1[0], r2[0])});
      check($sformatf("n16.ovf #%0d", k), {63'd0, ovf16}, {63'd0, ovf_model(a16[15], b16[15], r17[15])});
`endif
    end

    // N=16 boundaries, then hold
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; tick();
    check("n16.max", {47'd0, cout16, sum16}, {47'd0, 1'b1, 16'hFFFF});
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; tick();
    check("n16.wrap", {47'd0, cout16, sum16}, {47'd0, 1'b1, 16'h0000});
    held_s = sum4; held_c = cout4;
    vin16 = 1'b0; a16 = 16'hxxxx; b16 = 16'hxxxx; tick();
    check("n16.hold", {46'd0, vout16, cout16, sum16}, {46'd0, 1'b0, 1'b1, 16'h0000});
    check("n4.still", {59'd0, cout4, sum4}, {59'd0, held_c, held_s});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
